// File: rtl/pifo_pop_drain.sv
// Pop-side sequencer and order checker for the PIFO: issues a programmed number of
// pops, captures each returned word after RD_LAT cycles and flags priority decreases.
module pifo_pop_drain #(
    parameter int unsigned PTW     = 10,
    parameter int unsigned MTW     = 0,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned POP_GAP = 1,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_num_pops,
    input  logic                 i_pause,
    output logic                 o_pop,
    input  logic [PTW+MTW-1:0]   i_pop_data,
    output logic                 o_data_vld,
    output logic [PTW+MTW-1:0]   o_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err_order,
    output logic [CNT_W-1:0]     o_err_cnt,
    output logic [CNT_W-1:0]     o_pop_cnt
);

    localparam int unsigned DW       = PTW + MTW;
    localparam int unsigned GW       = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;
    localparam int unsigned GAP_LAST = (POP_GAP > 0) ? POP_GAP - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_issued;
    logic [GW-1:0]      r_gap;
    logic [RD_LAT-1:0]  r_tag;
    logic               r_first;
    logic [PTW-1:0]     r_last_pri;
    logic               w_pop;
    logic               w_last;
    logic               w_start;
    logic               w_tag_out;
    logic [PTW-1:0]     w_pri;

    assign w_start   = (r_state == S_IDLE) && i_start;
    assign w_last    = (r_issued == r_num - CNT_W'(1));
    assign w_tag_out = r_tag[RD_LAT-1];
    assign w_pri     = i_pop_data[DW-1:MTW];
    assign o_pop     = w_pop;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pop strobe
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_pops != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (!i_pause) begin
                    w_pop = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end else if (POP_GAP != 0) begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP_LAST)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (r_tag == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Run bookkeeping, capture path and order check
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_num       <= '0;
            r_issued    <= '0;
            r_gap       <= '0;
            r_tag       <= '0;
            r_first     <= 1'b0;
            r_last_pri  <= '0;
            o_data_vld  <= 1'b0;
            o_data      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err_order <= 1'b0;
            o_err_cnt   <= '0;
            o_pop_cnt   <= '0;
        end else begin
            r_tag      <= (r_tag << 1) | RD_LAT'(w_pop);
            o_busy     <= w_state_nxt inside {S_ISSUE, S_GAP, S_DRAIN};
            o_done     <= (w_state_nxt == S_DONE);
            o_data_vld <= w_tag_out;

            if (w_pop) begin
                r_issued <= r_issued + CNT_W'(1);
            end

            if (r_state == S_GAP) begin
                r_gap <= r_gap + GW'(1);
            end else begin
                r_gap <= '0;
            end

            if (w_tag_out) begin
                o_data     <= i_pop_data;
                o_pop_cnt  <= o_pop_cnt + CNT_W'(1);
                r_last_pri <= w_pri;
                r_first    <= 1'b0;
                if (!r_first && (w_pri < r_last_pri)) begin
                    o_err_order <= 1'b1;
                    if (o_err_cnt != '1) begin
                        o_err_cnt <= o_err_cnt + CNT_W'(1);
                    end
                end
            end

            // Accepted start opens a fresh run
            if (w_start) begin
                r_num       <= i_num_pops;
                r_issued    <= '0;
                o_pop_cnt   <= '0;
                o_err_cnt   <= '0;
                o_err_order <= 1'b0;
                r_first     <= 1'b1;
            end
        end
    end

endmodule
